// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg: mode encodings and shift-direction constants shared by univ_shift_reg and shift_word_counter
package univ_shift_reg_pkg;
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
endpackage

// File: rtl/univ_shift_reg_counter.sv
// shift_word_counter: counts same-direction shifts (clk, reset active-low async, shift/dir/restart in; cnt, registered done pulse out)
module shift_word_counter
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          shift,
  input  logic          dir,
  input  logic          restart,
  output logic [CW-1:0] cnt,
  output logic          done
);
  logic dir_q;
  logic wrap;
  assign wrap = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt   <= '0;
      dir_q <= DIR_RIGHT;
      done  <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (!shift) begin
      done <= 1'b0;
    end else if (dir != dir_q) begin
      cnt   <= CW'(1);
      dir_q <= dir;
      done  <= 1'b0;
    end else begin
      cnt  <= wrap ? '0 : cnt + CW'(1);
      done <= wrap;
    end
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: hold/shift-right/shift-left/load register (clk, reset active-low async, clr, en, mode, s_in_r, s_in_l, p_in in; q, s_out_r, s_out_l, word_done out)
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             s_in_r,
  input  logic             s_in_l,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] q,
  output logic             s_out_r,
  output logic             s_out_l,
  output logic             word_done
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt;
  logic             shift;
  logic             restart;
  always_comb begin
    q_nxt = (mode == MODE_SHR)  ? {s_in_r, q[WIDTH-1:1]} :
            (mode == MODE_SHL)  ? {q[WIDTH-2:0], s_in_l} :
            (mode == MODE_LOAD) ? p_in : q;
  end
  assign shift   = en & ~clr & ((mode == MODE_SHR) | (mode == MODE_SHL));
  assign restart = clr | (en & (mode == MODE_LOAD));
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= q_nxt;
  assign s_out_r = q[0];
  assign s_out_l = q[WIDTH-1];
  shift_word_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .shift  (shift),
    .dir    ((mode == MODE_SHL) ? DIR_LEFT : DIR_RIGHT),
    .restart(restart),
    .cnt    (cnt),
    .done   (word_done)
  );
  cnt_range: assert property (@(posedge clk) disable iff (!reset) cnt <= CW'(WIDTH - 1));
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: table-driven and scoreboard checks of univ_shift_reg at WIDTH=4
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;
  localparam int W = 4;
  logic clk = 1'b0, reset = 1'b1, clr = 1'b0, en = 1'b0, s_in_r = 1'b0, s_in_l = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [W-1:0] p_in = '0;
  logic [W-1:0] q;
  logic s_out_r, s_out_l, word_done;
  typedef struct {
    logic clr;
    logic en;
    logic [1:0] mode;
    logic sir;
    logic sil;
    logic [W-1:0] p;
    logic [W-1:0] eq;
    logic ewd;
    logic [1:0] ecnt;
    string nm;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  int checks = 0, failures = 0;
  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .mode(mode), .s_in_r(s_in_r), .s_in_l(s_in_l),
    .p_in(p_in), .q(q), .s_out_r(s_out_r), .s_out_l(s_out_l), .word_done(word_done)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic c, input logic e, input logic [1:0] m, input logic r, input logic l,
                              input logic [W-1:0] p, input logic [W-1:0] eq, input logic wd,
                              input logic [1:0] ec, input string nm);
    vec_t v;
    v.clr = c; v.en = e; v.mode = m; v.sir = r; v.sil = l; v.p = p;
    v.eq = eq; v.ewd = wd; v.ecnt = ec; v.nm = nm;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic pop_check();
    vec_t v;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    v = sb.pop_front();
    chk({v.nm, ".q"}, 32'(q), 32'(v.eq));
    chk({v.nm, ".word_done"}, 32'(word_done), 32'(v.ewd));
    chk({v.nm, ".cnt"}, 32'(dut.u_cnt.cnt), 32'(v.ecnt));
    chk({v.nm, ".s_out_r"}, 32'(s_out_r), 32'(v.eq[0]));
    chk({v.nm, ".s_out_l"}, 32'(s_out_l), 32'(v.eq[W-1]));
  endtask
  task automatic drive(input vec_t v);
    @(negedge clk);
    clr = v.clr; en = v.en; mode = v.mode; s_in_r = v.sir; s_in_l = v.sil; p_in = v.p;
    sb.push_back(v);
    @(posedge clk);
    #1;
    pop_check();
  endtask
  initial begin
    logic [W-1:0] eq;
    int pulses, last;
    #2 reset = 1'b0;
    {clr, en, mode, s_in_r, s_in_l, p_in} = 10'($urandom);
    #1;
    chk("rst_async_q", 32'(q), 32'd0);
    chk("rst_async_wd", 32'(word_done), 32'd0);
    chk("rst_async_cnt", 32'(dut.u_cnt.cnt), 32'd0);
    repeat (6) begin
      #3 {clr, en, mode, s_in_r, s_in_l, p_in} = 10'($urandom);
      chk("rst_hold_q", 32'(q), 32'd0);
      chk("rst_hold_wd", 32'(word_done), 32'd0);
    end
    @(negedge clk);
    clr = 1'b0; en = 1'b0; mode = MODE_HOLD;
    reset = 1'b1;
    tbl.push_back(mk(0, 1, MODE_LOAD, 0, 0, 4'b1011, 4'b1011, 0, 0, "load_1011"));
    tbl.push_back(mk(0, 1, MODE_LOAD, 0, 0, 4'b0000, 4'b0000, 0, 0, "load_0a"));
    tbl.push_back(mk(0, 1, MODE_SHR,  1, 0, 4'b0000, 4'b1000, 0, 1, "shr1"));
    tbl.push_back(mk(0, 1, MODE_SHR,  0, 0, 4'b0000, 4'b0100, 0, 2, "shr2"));
    tbl.push_back(mk(0, 1, MODE_SHR,  1, 0, 4'b0000, 4'b1010, 0, 3, "shr3"));
    tbl.push_back(mk(0, 1, MODE_SHR,  1, 0, 4'b0000, 4'b1101, 1, 0, "shr4"));
    tbl.push_back(mk(0, 1, MODE_HOLD, 0, 0, 4'b0000, 4'b1101, 0, 0, "hold_after_word"));
    tbl.push_back(mk(0, 1, MODE_LOAD, 0, 0, 4'b1001, 4'b1001, 0, 0, "load_1001"));
    tbl.push_back(mk(0, 1, MODE_SHL,  0, 0, 4'b0000, 4'b0010, 0, 1, "shl1"));
    tbl.push_back(mk(0, 1, MODE_SHL,  0, 0, 4'b0000, 4'b0100, 0, 2, "shl2"));
    tbl.push_back(mk(0, 1, MODE_SHR,  1, 0, 4'b0000, 4'b1010, 0, 1, "dir_change"));
    tbl.push_back(mk(0, 1, MODE_LOAD, 0, 0, 4'b0000, 4'b0000, 0, 0, "load_0b"));
    tbl.push_back(mk(0, 1, MODE_SHR,  1, 0, 4'b0000, 4'b1000, 0, 1, "gap_shr1"));
    tbl.push_back(mk(0, 1, MODE_SHR,  0, 0, 4'b0000, 4'b0100, 0, 2, "gap_shr2"));
    tbl.push_back(mk(0, 1, MODE_SHR,  1, 0, 4'b0000, 4'b1010, 0, 3, "gap_shr3"));
    tbl.push_back(mk(0, 0, MODE_SHR,  1, 0, 4'b0000, 4'b1010, 0, 3, "gap_en0a"));
    tbl.push_back(mk(0, 0, MODE_SHR,  0, 1, 4'b0000, 4'b1010, 0, 3, "gap_en0b"));
    tbl.push_back(mk(0, 1, MODE_SHR,  0, 0, 4'b0000, 4'b0101, 1, 0, "gap_shr4"));
    tbl.push_back(mk(0, 1, MODE_HOLD, 0, 0, 4'b0000, 4'b0101, 0, 0, "gap_hold"));
    tbl.push_back(mk(0, 1, MODE_LOAD, 0, 0, 4'b0000, 4'b0000, 0, 0, "load_0c"));
    tbl.push_back(mk(0, 1, MODE_SHL,  0, 1, 4'b0000, 4'b0001, 0, 1, "lw1"));
    tbl.push_back(mk(0, 1, MODE_SHL,  0, 1, 4'b0000, 4'b0011, 0, 2, "lw2"));
    tbl.push_back(mk(0, 1, MODE_HOLD, 0, 1, 4'b0000, 4'b0011, 0, 2, "lw_hold"));
    tbl.push_back(mk(0, 1, MODE_SHL,  0, 1, 4'b0000, 4'b0111, 0, 3, "lw3"));
    tbl.push_back(mk(0, 1, MODE_SHL,  0, 1, 4'b0000, 4'b1111, 1, 0, "lw4"));
    tbl.push_back(mk(1, 1, MODE_LOAD, 0, 0, 4'b1111, 4'b0000, 0, 0, "clr_over_load"));
    tbl.push_back(mk(0, 1, MODE_LOAD, 0, 0, 4'b1111, 4'b1111, 0, 0, "load_1111"));
    tbl.push_back(mk(1, 0, MODE_SHR,  1, 1, 4'b1111, 4'b0000, 0, 0, "clr_en0"));
    foreach (tbl[i]) drive(tbl[i]);
    drive(mk(0, 1, MODE_LOAD, 0, 0, 4'b0000, 4'b0000, 0, 0, "cont_load"));
    eq = '0;
    pulses = 0;
    last = -1;
    for (int i = 0; i < 12; i++) begin
      logic b;
      b = 1'($urandom_range(0, 1));
      eq = {b, eq[W-1:1]};
      drive(mk(0, 1, MODE_SHR, b, 0, 4'b0000, eq, (i % 4) == 3, 2'((i + 1) % 4), $sformatf("cont%0d", i)));
      if (word_done) begin
        pulses++;
        if (last >= 0) chk("cont_spacing", 32'(i - last), 32'd4);
        last = i;
      end
    end
    chk("cont_pulses", 32'(pulses), 32'd3);
    eq = {1'b1, eq[W-1:1]};
    drive(mk(0, 1, MODE_SHR, 1, 0, 4'b0000, eq, 0, 1, "mid_shr1"));
    eq = {1'b1, eq[W-1:1]};
    drive(mk(0, 1, MODE_SHR, 1, 0, 4'b0000, eq, 0, 2, "mid_shr2"));
    @(posedge clk);
    #2 reset = 1'b0;
    en = 1'b0;
    #1;
    chk("mid_rst_q", 32'(q), 32'd0);
    chk("mid_rst_wd", 32'(word_done), 32'd0);
    chk("mid_rst_cnt", 32'(dut.u_cnt.cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(mk(0, 1, MODE_SHR, 1, 0, 4'b0000, 4'b1000, 0, 1, "post_rst1"));
    drive(mk(0, 1, MODE_SHR, 0, 0, 4'b0000, 4'b0100, 0, 2, "post_rst2"));
    drive(mk(0, 1, MODE_SHR, 0, 0, 4'b0000, 4'b0010, 0, 3, "post_rst3"));
    drive(mk(0, 1, MODE_SHR, 1, 0, 4'b0000, 4'b1001, 1, 0, "post_rst4"));
    drive(mk(0, 0, MODE_SHR, 1, 0, 4'b0000, 4'b1001, 0, 0, "post_rst_idle"));
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits; legal range 2..32.
REQ-002 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1, reset, asynchronous, active-low; asserted when 0.
REQ-004 Port clr, input, 1, synchronous clear, active-high.
REQ-005 Port en, input, 1, clock enable for the data path and the counter.
REQ-006 Port mode, input, 2, 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 Port s_in_r, input, 1, serial input for right shifts; enters q[WIDTH-1].
REQ-008 Port s_in_l, input, 1, serial input for left shifts; enters q[0].
REQ-009 Port p_in, input, WIDTH, parallel load data.
REQ-010 Port q, output, WIDTH, register contents.
REQ-011 Port s_out_r, output, 1, equals q[0] (right-shift serial output).
REQ-012 Port s_out_l, output, 1, equals q[WIDTH-1] (left-shift serial output).
REQ-013 Port word_done, output, 1, registered one-cycle pulse when WIDTH consecutive same-direction shifts complete.

Function
REQ-014 Update priority per edge SHALL be: reset, then clr, then en=0 (hold all state), then mode.
REQ-015 clr=1 SHALL set q=0, cnt=0 and word_done=0, regardless of en.
REQ-016 Mode 01 with en=1 SHALL perform q <= {s_in_r, q[WIDTH-1:1]}.
REQ-017 Mode 10 with en=1 SHALL perform q <= {q[WIDTH-2:0], s_in_l}.
REQ-018 Mode 11 with en=1 SHALL perform q <= p_in, cnt <= 0 and word_done <= 0.
REQ-019 Mode 00 or en=0 SHALL leave q and cnt unchanged and SHALL drive word_done to 0 next cycle.
REQ-020 An internal counter cnt, width clog2(WIDTH), SHALL count enabled shifts since the last load, clear, reset or direction change.
REQ-021 An internal 1-bit register dir SHALL record the direction of the last shift; a shift opposite to dir SHALL set cnt to 1 and update dir.
REQ-022 A same-direction shift with cnt = WIDTH-1 SHALL wrap cnt to 0 and assert word_done for exactly the next cycle.
REQ-023 A bit presented on s_in_r SHALL appear on s_out_r after exactly WIDTH enabled right shifts; the same holds for s_in_l and s_out_l under left shifts.
REQ-024 Back-to-back words SHALL be supported: continuous shifting SHALL produce word_done every WIDTH enabled shifts with no gap cycle.
REQ-025 Hold cycles (en=0 or mode 00) inside a word SHALL not break the count; the word completes on the WIDTH-th enabled shift.
REQ-026 s_out_r and s_out_l SHALL be pure wiring from q, with no additional logic.

Reset
REQ-027 While reset=0, q=0, cnt=0, dir=right and word_done=0 SHALL hold immediately, independent of clk.
REQ-028 Deassertion of reset SHALL take effect on the next rising edge; reset asserted mid-word SHALL discard the partial count.

Structure
REQ-029 A shared package SHALL define the mode encodings MODE_HOLD, MODE_SHR, MODE_SHL and MODE_LOAD, plus the direction constants.
REQ-030 The counter and wrap logic SHALL be a sub-module named shift_word_counter (inputs: shift, dir, restart; outputs: cnt, done).
REQ-031 All outputs SHALL be free of combinational paths from inputs.

Verification (WIDTH=4)
REQ-032 reset=0 with random inputs toggling -> q=0000 and word_done=0 with no clock edge required; release, then load 1011 -> q=1011.
REQ-033 Load 0000, then right-shift s_in_r=1,0,1,1 over 4 enabled cycles -> q=1101, word_done high only on the cycle after the 4th shift; s_out_r first shows a 1 after the 4th shift.
REQ-034 Load 1001, then left-shift s_in_l=0 twice -> q=0100; one right shift with s_in_r=1 -> q=1010 and cnt=1 (direction change).
REQ-035 Right-shift 3 bits, en=0 for 2 cycles, then 1 more shift -> word_done on the 4th enabled shift only; q is unchanged during the hold cycles.
REQ-036 12 continuous right shifts -> word_done pulses exactly 3 times, spaced 4 cycles apart; reset pulsed after the 2nd shift of a word -> cnt restarts and the next word_done comes 4 shifts after release.
REQ-037 clr=1 together with mode=11, en=1 and p_in=1111 -> q=0000 (clr wins); with clr=1 and en=0 -> q=0000.
